// File: rtl/chacha_pkg.sv
// Shared types, constants and helpers for the ChaCha block core.
package chacha_pkg;

  localparam int unsigned WORD_W     = 32;
  localparam int unsigned NWORDS     = 16;
  localparam int unsigned ROUNDS_DEF = 20;

  localparam logic [WORD_W-1:0] SIGMA0 = 32'h61707865;
  localparam logic [WORD_W-1:0] SIGMA1 = 32'h3320646e;
  localparam logic [WORD_W-1:0] SIGMA2 = 32'h79622d32;
  localparam logic [WORD_W-1:0] SIGMA3 = 32'h6b206574;

  typedef logic [WORD_W-1:0] word_t;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ROUND = 2'd1,
    DONE  = 2'd2
  } state_t;

  function automatic word_t rotl(input word_t x, input int unsigned n);
    return (x << n) | (x >> (WORD_W - n));
  endfunction

  // State index of word 'row' (a=0..d=3) for quarter round 'qr'; diagonal rounds skew each row by its number.
  function automatic logic [3:0] qr_idx(input logic diag, input int unsigned qr,
                                        input int unsigned row);
    int unsigned col;
    col = diag ? ((qr + row) % 4) : qr;
    return 4'(row * 4 + col);
  endfunction

endpackage

// File: rtl/chacha_block_core_quarterround.sv
// Combinational ChaCha quarter round (add-xor-rotate on four words).
module chacha_quarterround
  import chacha_pkg::*;
(
  input  word_t a,
  input  word_t b,
  input  word_t c,
  input  word_t d,
  output word_t a_c,
  output word_t b_c,
  output word_t c_c,
  output word_t d_c
);

  word_t a1, b1, c1, d1, a2, b2, c2, d2;

  always_comb begin
    a1 = a + b;
    d1 = rotl(d ^ a1, 16);
    c1 = c + d1;
    b1 = rotl(b ^ c1, 12);
    a2 = a1 + b1;
    d2 = rotl(d1 ^ a2, 8);
    c2 = c1 + d2;
    b2 = rotl(b1 ^ c2, 7);
    a_c = a2;
    b_c = b2;
    c_c = c2;
    d_c = d2;
  end

endmodule

// File: rtl/chacha_block_core.sv
// Iterative ChaCha block function: one column or diagonal round per clock, feed-forward add on the last.
module chacha_block_core
  import chacha_pkg::*;
#(
  parameter int unsigned ROUNDS = ROUNDS_DEF
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         in_valid,
  output logic         in_ready,
  input  logic [255:0] key,
  input  logic [31:0]  counter,
  input  logic [95:0]  nonce,
  output logic         out_valid,
  input  logic         out_ready,
  output logic [511:0] keystream
);

  localparam int unsigned RND_W = $clog2(ROUNDS);

  state_t           state, state_nxt;
  logic             accept_c, last_c, diag;
  logic [RND_W-1:0] rnd;
  word_t            init_q [NWORDS];
  word_t            work_q [NWORDS];
  word_t            start_c[NWORDS];
  word_t            round_c[NWORDS];
  word_t            qa[4], qb[4], qc[4], qd[4];
  word_t            qa_c[4], qb_c[4], qc_c[4], qd_c[4];

  assign diag = rnd[0];

  // Initial state layout: constants, key, counter, nonce.
  always_comb begin
    start_c[0] = SIGMA0;
    start_c[1] = SIGMA1;
    start_c[2] = SIGMA2;
    start_c[3] = SIGMA3;
    for (int i = 0; i < 8; i++) start_c[4+i] = key[32*i +: 32];
    start_c[12] = counter;
    for (int j = 0; j < 3; j++) start_c[13+j] = nonce[32*j +: 32];
  end

  always_comb begin
    for (int q = 0; q < 4; q++) begin
      qa[q] = work_q[qr_idx(diag, q, 0)];
      qb[q] = work_q[qr_idx(diag, q, 1)];
      qc[q] = work_q[qr_idx(diag, q, 2)];
      qd[q] = work_q[qr_idx(diag, q, 3)];
    end
  end

  for (genvar g = 0; g < 4; g++) begin : g_qr
    chacha_quarterround u_qr (
      .a   (qa[g]),
      .b   (qb[g]),
      .c   (qc[g]),
      .d   (qd[g]),
      .a_c (qa_c[g]),
      .b_c (qb_c[g]),
      .c_c (qc_c[g]),
      .d_c (qd_c[g])
    );
  end

  // Scatter quarter-round results back to the same state positions they were read from.
  always_comb begin
    round_c = work_q;
    for (int q = 0; q < 4; q++) begin
      round_c[qr_idx(diag, q, 0)] = qa_c[q];
      round_c[qr_idx(diag, q, 1)] = qb_c[q];
      round_c[qr_idx(diag, q, 2)] = qc_c[q];
      round_c[qr_idx(diag, q, 3)] = qd_c[q];
    end
  end

  always_comb begin
    state_nxt = state;
    accept_c  = 1'b0;
    last_c    = 1'b0;
    unique case (state)
      IDLE: begin
        if (in_valid) begin
          accept_c  = 1'b1;
          state_nxt = ROUND;
        end
      end
      ROUND: begin
        if (rnd == RND_W'(ROUNDS - 1)) begin
          last_c    = 1'b1;
          state_nxt = DONE;
        end
      end
      DONE: begin
        if (out_ready) state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      in_ready  <= 1'b1;
      out_valid <= 1'b0;
    end else begin
      state     <= state_nxt;
      in_ready  <= (state_nxt == IDLE);
      out_valid <= (state_nxt == DONE);
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rnd       <= '0;
      keystream <= '0;
      for (int i = 0; i < NWORDS; i++) begin
        init_q[i] <= '0;
        work_q[i] <= '0;
      end
    end else if (accept_c) begin
      rnd    <= '0;
      init_q <= start_c;
      work_q <= start_c;
    end else if (state == ROUND) begin
      rnd    <= rnd + 1'b1;
      work_q <= round_c;
      if (last_c) begin
        for (int k = 0; k < NWORDS; k++) keystream[32*k +: 32] <= round_c[k] + init_q[k];
      end
    end
  end

endmodule

// File: tb/tb_chacha_block_core.sv
// Directed bench for chacha_block_core: RFC 8439 vectors, stall, mid-run reset, back-to-back.
module tb_chacha_block_core;

  logic         clk = 1'b0;
  logic         rst_n;
  logic         in_valid;
  logic         in_ready;
  logic [255:0] key;
  logic [31:0]  counter;
  logic [95:0]  nonce;
  logic         out_valid;
  logic         out_ready;
  logic [511:0] keystream;

  int n_total = 0;
  int n_bad   = 0;

  always #5 clk = ~clk;

  chacha_block_core dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .key       (key),
    .counter   (counter),
    .nonce     (nonce),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .keystream (keystream)
  );

  task automatic check_eq(input string tag, input logic [511:0] obs, input logic [511:0] exp);
    n_total++;
    if (obs !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h want %h", tag, obs, exp);
    end
  endtask

  function automatic logic [127:0] ref_qr(input logic [31:0] a0, b0, c0, d0);
    logic [31:0] a, b, c, d;
    a = a0; b = b0; c = c0; d = d0;
    a = a + b; d = d ^ a; d = {d[15:0], d[31:16]};
    c = c + d; b = b ^ c; b = {b[19:0], b[31:20]};
    a = a + b; d = d ^ a; d = {d[23:0], d[31:24]};
    c = c + d; b = b ^ c; b = {b[24:0], b[31:25]};
    return {a, b, c, d};
  endfunction

  function automatic logic [511:0] chacha_ref(input logic [255:0] k, input logic [31:0] c,
                                              input logic [95:0] n);
    logic [31:0]  s[16];
    logic [31:0]  w[16];
    logic [511:0] r;
    s[0] = 32'h61707865; s[1] = 32'h3320646e; s[2] = 32'h79622d32; s[3] = 32'h6b206574;
    for (int i = 0; i < 8; i++) s[4+i] = k[32*i +: 32];
    s[12] = c;
    for (int j = 0; j < 3; j++) s[13+j] = n[32*j +: 32];
    w = s;
    for (int dr = 0; dr < 10; dr++) begin
      {w[0], w[4], w[8],  w[12]} = ref_qr(w[0], w[4], w[8],  w[12]);
      {w[1], w[5], w[9],  w[13]} = ref_qr(w[1], w[5], w[9],  w[13]);
      {w[2], w[6], w[10], w[14]} = ref_qr(w[2], w[6], w[10], w[14]);
      {w[3], w[7], w[11], w[15]} = ref_qr(w[3], w[7], w[11], w[15]);
      {w[0], w[5], w[10], w[15]} = ref_qr(w[0], w[5], w[10], w[15]);
      {w[1], w[6], w[11], w[12]} = ref_qr(w[1], w[6], w[11], w[12]);
      {w[2], w[7], w[8],  w[13]} = ref_qr(w[2], w[7], w[8],  w[13]);
      {w[3], w[4], w[9],  w[14]} = ref_qr(w[3], w[4], w[9],  w[14]);
    end
    for (int i = 0; i < 16; i++) r[32*i +: 32] = w[i] + s[i];
    return r;
  endfunction

  // Present a request at the current negedge; inputs are scrambled right after acceptance.
  task automatic request(input logic [255:0] k, input logic [31:0] c, input logic [95:0] n);
    key = k; counter = c; nonce = n; in_valid = 1'b1;
    @(posedge clk); #1;
    in_valid = 1'b0; key = ~k; counter = ~c; nonce = ~n;
  endtask

  task automatic wait_out(output int cyc);
    cyc = 0;
    while (!out_valid && cyc < 100) begin
      @(posedge clk); #1;
      cyc++;
    end
  endtask

  task automatic handshake;
    @(negedge clk); out_ready = 1'b1;
    @(posedge clk); #1;
    out_ready = 1'b0;
  endtask

  logic [255:0] rfc_key;
  logic [95:0]  rfc_nonce;
  logic [511:0] snap, exp_ks;
  int           lat;

  initial begin
    for (int i = 0; i < 32; i++) rfc_key[8*i +: 8] = 8'(i);
    rfc_nonce = {32'h00000000, 32'h4a000000, 32'h09000000};
    in_valid = 1'b0; out_ready = 1'b0; key = '0; counter = '0; nonce = '0;
    rst_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    check_eq("rst_out_valid", 512'(out_valid), 512'd0);
    check_eq("rst_keystream", keystream, 512'd0);
    check_eq("rst_in_ready", 512'(in_ready), 512'd1);
    @(negedge clk); rst_n = 1'b1;

    // RFC 8439 2.3.2 block
    @(negedge clk);
    request(rfc_key, 32'd1, rfc_nonce);
    check_eq("t1_in_ready_busy", 512'(in_ready), 512'd0);
    wait_out(lat);
    check_eq("t1_latency", 512'(lat), 512'd20);
    check_eq("t1_word0", 512'(keystream[31:0]), 512'(32'he4e7f110));
    check_eq("t1_word1", 512'(keystream[63:32]), 512'(32'h15593bd1));
    check_eq("t1_word15", 512'(keystream[511:480]), 512'(32'h4e3c50a2));
    check_eq("t1_block", keystream, chacha_ref(rfc_key, 32'd1, rfc_nonce));

    // Stall with out_ready low; a stray in_valid pulse must not be taken
    snap = keystream;
    for (int s = 0; s < 5; s++) begin
      @(negedge clk); in_valid = (s == 2);
      @(posedge clk); #1;
      check_eq("stall_out_valid", 512'(out_valid), 512'd1);
      check_eq("stall_keystream", keystream, snap);
      check_eq("stall_in_ready", 512'(in_ready), 512'd0);
    end
    in_valid = 1'b0;
    handshake();
    check_eq("hs_out_valid", 512'(out_valid), 512'd0);
    check_eq("hs_in_ready", 512'(in_ready), 512'd1);
    @(posedge clk); #1;
    check_eq("idle_no_accept", 512'(in_ready), 512'd1);

    // RFC 8439 A.1 test vector #1
    @(negedge clk);
    request('0, 32'd0, '0);
    wait_out(lat);
    check_eq("t2_latency", 512'(lat), 512'd20);
    check_eq("t2_word0", 512'(keystream[31:0]), 512'(32'hade0b876));
    check_eq("t2_word1", 512'(keystream[63:32]), 512'(32'h903df1a0));
    check_eq("t2_block", keystream, chacha_ref('0, 32'd0, '0));
    handshake();

    // Reset asserted mid-computation
    @(negedge clk);
    request(rfc_key, 32'd1, rfc_nonce);
    repeat (10) @(posedge clk);
    #1; rst_n = 1'b0;
    #1;
    check_eq("mid_rst_out_valid", 512'(out_valid), 512'd0);
    check_eq("mid_rst_keystream", keystream, 512'd0);
    check_eq("mid_rst_in_ready", 512'(in_ready), 512'd1);
    @(negedge clk); rst_n = 1'b1;
    @(posedge clk); #1;
    check_eq("post_rst_idle", 512'(out_valid), 512'd0);
    @(negedge clk);
    request(rfc_key, 32'd1, rfc_nonce);
    wait_out(lat);
    check_eq("t4_latency", 512'(lat), 512'd20);
    check_eq("t4_block", keystream, chacha_ref(rfc_key, 32'd1, rfc_nonce));
    handshake();

    // Back-to-back with out_ready held high
    @(negedge clk);
    out_ready = 1'b1; key = rfc_key; nonce = rfc_nonce; counter = 32'd1; in_valid = 1'b1;
    @(posedge clk); #1;
    check_eq("b2b_first_accept", 512'(in_ready), 512'd0);
    counter = 32'd2;
    wait_out(lat);
    check_eq("b2b_lat1", 512'(lat), 512'd20);
    check_eq("b2b_block1", keystream, chacha_ref(rfc_key, 32'd1, rfc_nonce));
    @(posedge clk); #1;
    check_eq("b2b_hs_out_valid", 512'(out_valid), 512'd0);
    check_eq("b2b_hs_in_ready", 512'(in_ready), 512'd1);
    @(posedge clk); #1;
    check_eq("b2b_second_accept", 512'(in_ready), 512'd0);
    in_valid = 1'b0;
    wait_out(lat);
    check_eq("b2b_lat2", 512'(lat), 512'd20);
    check_eq("b2b_block2", keystream, chacha_ref(rfc_key, 32'd2, rfc_nonce));
    @(posedge clk); #1;
    check_eq("b2b_done", 512'(out_valid), 512'd0);

    // Counter at all-ones: no carry into the nonce words
    @(negedge clk);
    out_ready = 1'b0;
    request(rfc_key, 32'hffffffff, rfc_nonce);
    wait_out(lat);
    exp_ks = chacha_ref(rfc_key, 32'hffffffff, rfc_nonce);
    check_eq("ctr_max_word12", 512'(keystream[415:384]), 512'(exp_ks[415:384]));
    check_eq("ctr_max_block", keystream, exp_ks);
    handshake();

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
